mif_arbiter_2to1: RTL and testbench

- Two-client arbiter for a single memory-interface (MIF) port, e.g. the behavioural backup memory.
- Shares one downstream request/write-data/response channel between client 0 and client 1.
- Holds the grant for the full write-data burst.
- Extends the tag with a client-ID bit so responses are routed back to the issuing client.
- Sits between the two uncore MIF masters and the memory model.

---
 rtl/mif_arbiter_2to1.sv | 193 +++++++++++++++++++
 tb/tb_mif_arbiter_2to1.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mif_arbiter_2to1.sv
// mif_arbiter_2to1
//   Shares one downstream memory-interface (MIF) port between two clients.
//   A granted write keeps ownership of the port until all DATA_CYCLES
//   write beats have been handed over. The client index is prepended to the
//   downstream tag, so read responses can be routed back to the issuing
//   client.
//
//   Optional build macro MIF_ARB_ROUND_ROBIN_EN:
//     defined   -> round-robin on contention (client 0 wins the first one)
//     undefined -> fixed priority, client 0 always wins contention
//
// Handshake semantics (all channels): a transfer happens in a cycle where
// valid and ready are both high. A valid raised by a client is never
// dropped by this block. Write data offered outside a burst sees ready=0
// and stays pending at the client.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cN_req_*              client N request channel (valid/ready/rw/addr/tag)
//   cN_req_data_*         client N write-data channel
//   cN_resp_*             client N read response (no backpressure)
//   mem_req_*             downstream request channel, tag = {client_id, tag}
//   mem_req_data_*        downstream write-data channel
//   mem_resp_*            downstream read response
module mif_arbiter_2to1 #(
  parameter int ADDR_BITS   = 26,
  parameter int DATA_BITS   = 128,
  parameter int CTAG_BITS   = 5,
  parameter int DATA_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 c0_req_valid,
  output logic                 c0_req_ready,
  input  logic                 c0_req_rw,
  input  logic [ADDR_BITS-1:0] c0_req_addr,
  input  logic [CTAG_BITS-1:0] c0_req_tag,
  input  logic                 c0_req_data_valid,
  output logic                 c0_req_data_ready,
  input  logic [DATA_BITS-1:0] c0_req_data_bits,
  output logic                 c0_resp_valid,
  output logic [DATA_BITS-1:0] c0_resp_data,
  output logic [CTAG_BITS-1:0] c0_resp_tag,
  input  logic                 c1_req_valid,
  output logic                 c1_req_ready,
  input  logic                 c1_req_rw,
  input  logic [ADDR_BITS-1:0] c1_req_addr,
  input  logic [CTAG_BITS-1:0] c1_req_tag,
  input  logic                 c1_req_data_valid,
  output logic                 c1_req_data_ready,
  input  logic [DATA_BITS-1:0] c1_req_data_bits,
  output logic                 c1_resp_valid,
  output logic [DATA_BITS-1:0] c1_resp_data,
  output logic [CTAG_BITS-1:0] c1_resp_tag,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic                 mem_req_rw,
  output logic [ADDR_BITS-1:0] mem_req_addr,
  output logic [CTAG_BITS:0]   mem_req_tag,
  output logic                 mem_req_data_valid,
  input  logic                 mem_req_data_ready,
  output logic [DATA_BITS-1:0] mem_req_data_bits,
  input  logic                 mem_resp_valid,
  input  logic [DATA_BITS-1:0] mem_resp_data,
  input  logic [CTAG_BITS:0]   mem_resp_tag
);

  localparam int CNT_W = (DATA_CYCLES > 1) ? $clog2(DATA_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_CYCLES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    WDATA = 1'b1
  } state_t;

  state_t           state, state_next;
  logic             owner, owner_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             grant;
  logic             req_fire;
  logic             data_fire;

  // A request offered but stalled last cycle keeps its grant while its
  // client still holds valid, so the downstream sees stable rw/addr/tag.
  logic             hold_valid;
  logic             hold_id;
  logic             hold_live;

  assign hold_live = hold_valid && (hold_id ? c1_req_valid : c0_req_valid);

`ifdef MIF_ARB_ROUND_ROBIN_EN
  logic last_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (req_fire) begin
      last_grant <= grant;
    end
  end
`endif

  always_comb begin
    grant = 1'b0;
    if (hold_live) begin
      grant = hold_id;
    end else if (c0_req_valid && c1_req_valid) begin
`ifdef MIF_ARB_ROUND_ROBIN_EN
      grant = ~last_grant;
`else
      grant = 1'b0;
`endif
    end else begin
      grant = c1_req_valid;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      cnt        <= '0;
      hold_valid <= 1'b0;
      hold_id    <= 1'b0;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      cnt        <= cnt_next;
      hold_valid <= mem_req_valid && !mem_req_ready;
      hold_id    <= grant;
    end
  end

  // Next state and channel outputs
  always_comb begin
    state_next         = state;
    owner_next         = owner;
    cnt_next           = cnt;
    req_fire           = 1'b0;
    data_fire          = 1'b0;
    mem_req_valid      = 1'b0;
    c0_req_ready       = 1'b0;
    c1_req_ready       = 1'b0;
    mem_req_data_valid = 1'b0;
    c0_req_data_ready  = 1'b0;
    c1_req_data_ready  = 1'b0;
    mem_req_rw         = grant ? c1_req_rw   : c0_req_rw;
    mem_req_addr       = grant ? c1_req_addr : c0_req_addr;
    mem_req_tag        = {grant, (grant ? c1_req_tag : c0_req_tag)};
    mem_req_data_bits  = owner ? c1_req_data_bits : c0_req_data_bits;

    if (!reset) begin
      case (state)
        IDLE: begin
          mem_req_valid = grant ? c1_req_valid : c0_req_valid;
          c0_req_ready  = mem_req_ready && !grant;
          c1_req_ready  = mem_req_ready && grant;
          req_fire      = mem_req_valid && mem_req_ready;
          if (req_fire && mem_req_rw) begin
            state_next = WDATA;
            owner_next = grant;
            cnt_next   = '0;
          end
        end
        WDATA: begin
          mem_req_data_valid = owner ? c1_req_data_valid : c0_req_data_valid;
          c0_req_data_ready  = mem_req_data_ready && !owner;
          c1_req_data_ready  = mem_req_data_ready && owner;
          data_fire          = mem_req_data_valid && mem_req_data_ready;
          if (data_fire) begin
            if (cnt == CNT_LAST) begin
              state_next = IDLE;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt + CNT_W'(1);
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Responses bypass the state machine: routed by the client-id tag bit.
  assign c0_resp_valid = !reset && mem_resp_valid && !mem_resp_tag[CTAG_BITS];
  assign c1_resp_valid = !reset && mem_resp_valid &&  mem_resp_tag[CTAG_BITS];
  assign c0_resp_tag   = mem_resp_tag[CTAG_BITS-1:0];
  assign c1_resp_tag   = mem_resp_tag[CTAG_BITS-1:0];
  assign c0_resp_data  = mem_resp_data;
  assign c1_resp_data  = mem_resp_data;

endmodule

// File: tb/tb_mif_arbiter_2to1.sv
// Testbench for mif_arbiter_2to1: directed scenarios with literal
// expectations followed by randomized traffic, all checked every cycle
// against a transaction-level model of the arbiter.
module tb_mif_arbiter_2to1;

  localparam int AB = 26;
  localparam int DB = 128;
  localparam int CB = 5;
  localparam int DC = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          c0_req_valid, c0_req_ready, c0_req_rw;
  logic [AB-1:0] c0_req_addr;
  logic [CB-1:0] c0_req_tag;
  logic          c0_req_data_valid, c0_req_data_ready;
  logic [DB-1:0] c0_req_data_bits;
  logic          c0_resp_valid;
  logic [DB-1:0] c0_resp_data;
  logic [CB-1:0] c0_resp_tag;
  logic          c1_req_valid, c1_req_ready, c1_req_rw;
  logic [AB-1:0] c1_req_addr;
  logic [CB-1:0] c1_req_tag;
  logic          c1_req_data_valid, c1_req_data_ready;
  logic [DB-1:0] c1_req_data_bits;
  logic          c1_resp_valid;
  logic [DB-1:0] c1_resp_data;
  logic [CB-1:0] c1_resp_tag;
  logic          mem_req_valid, mem_req_ready, mem_req_rw;
  logic [AB-1:0] mem_req_addr;
  logic [CB:0]   mem_req_tag;
  logic          mem_req_data_valid, mem_req_data_ready;
  logic [DB-1:0] mem_req_data_bits;
  logic          mem_resp_valid;
  logic [DB-1:0] mem_resp_data;
  logic [CB:0]   mem_resp_tag;

  mif_arbiter_2to1 #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .CTAG_BITS(CB), .DATA_CYCLES(DC)
  ) dut (
    .clk(clk), .reset(reset),
    .c0_req_valid(c0_req_valid), .c0_req_ready(c0_req_ready), .c0_req_rw(c0_req_rw),
    .c0_req_addr(c0_req_addr), .c0_req_tag(c0_req_tag),
    .c0_req_data_valid(c0_req_data_valid), .c0_req_data_ready(c0_req_data_ready),
    .c0_req_data_bits(c0_req_data_bits),
    .c0_resp_valid(c0_resp_valid), .c0_resp_data(c0_resp_data), .c0_resp_tag(c0_resp_tag),
    .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready), .c1_req_rw(c1_req_rw),
    .c1_req_addr(c1_req_addr), .c1_req_tag(c1_req_tag),
    .c1_req_data_valid(c1_req_data_valid), .c1_req_data_ready(c1_req_data_ready),
    .c1_req_data_bits(c1_req_data_bits),
    .c1_resp_valid(c1_resp_valid), .c1_resp_data(c1_resp_data), .c1_resp_tag(c1_resp_tag),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_tag(mem_resp_tag)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [DB-1:0] exp_q[$];
  int data_hs = 0;

  task automatic chk(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_owner: -1 when the port is open for arbitration, else the client
  // whose write burst is in progress. m_held: client whose stalled request
  // must keep the grant, -1 if none.
  int m_owner = -1;
  int m_beats = 0;
  int m_last  = 1;
  int m_held  = -1;

  task automatic compare_cycle();
    bit v[2];
    bit rw_g, dv, any;
    int g;
    v[0] = c0_req_valid;
    v[1] = c1_req_valid;

    if (reset) begin
      chk("rst_mem_req_valid", mem_req_valid, 0);
      chk("rst_mem_data_valid", mem_req_data_valid, 0);
      chk("rst_c0_req_ready", c0_req_ready, 0);
      chk("rst_c1_req_ready", c1_req_ready, 0);
      chk("rst_c0_data_ready", c0_req_data_ready, 0);
      chk("rst_c1_data_ready", c1_req_data_ready, 0);
      chk("rst_c0_resp_valid", c0_resp_valid, 0);
      chk("rst_c1_resp_valid", c1_resp_valid, 0);
      m_owner = -1; m_beats = 0; m_last = 1; m_held = -1;
      return;
    end

    chk("c0_resp_valid", c0_resp_valid, mem_resp_valid && (mem_resp_tag[CB] == 1'b0));
    chk("c1_resp_valid", c1_resp_valid, mem_resp_valid && (mem_resp_tag[CB] == 1'b1));
    if (mem_resp_valid) begin
      chk("c0_resp_tag", c0_resp_tag, mem_resp_tag[CB-1:0]);
      chk("c1_resp_tag", c1_resp_tag, mem_resp_tag[CB-1:0]);
      chk("c0_resp_data", c0_resp_data, mem_resp_data);
      chk("c1_resp_data", c1_resp_data, mem_resp_data);
    end

    if (mem_req_data_valid && mem_req_data_ready) begin
      data_hs++;
      if (exp_q.size() > 0) chk("wbeat_order", mem_req_data_bits, exp_q.pop_front());
    end

    if (m_owner < 0) begin
      any = v[0] || v[1];
      if (m_held >= 0 && v[m_held]) g = m_held;
      else if (v[0] && v[1]) begin
`ifdef MIF_ARB_ROUND_ROBIN_EN
        g = 1 - m_last;
`else
        g = 0;
`endif
      end else g = v[1] ? 1 : 0;
      rw_g = (g == 1) ? c1_req_rw : c0_req_rw;

      chk("mem_req_valid", mem_req_valid, v[g]);
      chk("idle_data_valid", mem_req_data_valid, 0);
      chk("idle_c0_data_ready", c0_req_data_ready, 0);
      chk("idle_c1_data_ready", c1_req_data_ready, 0);
      if (any) begin
        chk("c0_req_ready", c0_req_ready, mem_req_ready && (g == 0));
        chk("c1_req_ready", c1_req_ready, mem_req_ready && (g == 1));
      end
      if (v[g]) begin
        chk("mem_req_rw", mem_req_rw, rw_g);
        chk("mem_req_addr", mem_req_addr, (g == 1) ? c1_req_addr : c0_req_addr);
        chk("mem_req_tag", mem_req_tag, {g[0], ((g == 1) ? c1_req_tag : c0_req_tag)});
      end

      if (v[g] && mem_req_ready) begin
        m_last = g;
        m_held = -1;
        if (rw_g) begin
          m_owner = g;
          m_beats = 0;
        end
      end else if (v[g]) m_held = g;
      else m_held = -1;
    end else begin
      dv = (m_owner == 1) ? c1_req_data_valid : c0_req_data_valid;
      chk("wd_mem_req_valid", mem_req_valid, 0);
      chk("wd_c0_req_ready", c0_req_ready, 0);
      chk("wd_c1_req_ready", c1_req_ready, 0);
      chk("wd_data_valid", mem_req_data_valid, dv);
      chk("wd_c0_data_ready", c0_req_data_ready, (m_owner == 0) && mem_req_data_ready);
      chk("wd_c1_data_ready", c1_req_data_ready, (m_owner == 1) && mem_req_data_ready);
      if (dv) chk("wd_data_bits", mem_req_data_bits,
                  (m_owner == 1) ? c1_req_data_bits : c0_req_data_bits);
      if (dv && mem_req_data_ready) begin
        m_beats++;
        if (m_beats == DC) begin
          m_owner = -1;
          m_beats = 0;
        end
      end
      m_held = -1;
    end
  endtask

  always @(negedge clk) begin
    #2;
    compare_cycle();
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    c0_req_valid = 0; c0_req_rw = 0; c0_req_addr = '0; c0_req_tag = '0;
    c0_req_data_valid = 0; c0_req_data_bits = '0;
    c1_req_valid = 0; c1_req_rw = 0; c1_req_addr = '0; c1_req_tag = '0;
    c1_req_data_valid = 0; c1_req_data_bits = '0;
    mem_req_ready = 0; mem_req_data_ready = 0;
    mem_resp_valid = 0; mem_resp_data = '0; mem_resp_tag = '0;
  endtask

  task automatic do_reset();
    tick(); idle_inputs(); reset = 1;
    tick(); reset = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hs0;
    int beats;
    logic exp_g;

    idle_inputs();
    reset = 1;

    // Reset: outputs forced low even with every input asserted.
    tick();
    mem_req_ready = 1; mem_req_data_ready = 1; c0_req_valid = 1;
    c0_req_data_valid = 1; mem_resp_valid = 1;
    #3;
    chk("lit_rst_mem_req_valid", mem_req_valid, 0);
    chk("lit_rst_c0_req_ready", c0_req_ready, 0);
    chk("lit_rst_c0_resp_valid", c0_resp_valid, 0);
    tick(); reset = 0; idle_inputs();

    // Single read, response in the same cycle.
    tick();
    c0_req_valid = 1; c0_req_addr = 26'h10; c0_req_tag = 5'd3; mem_req_ready = 1;
    mem_resp_valid = 1; mem_resp_tag = 6'h03; mem_resp_data = 128'h1234;
    #3;
    chk("lit_rd_tag", mem_req_tag, 6'h03);
    chk("lit_rd_addr", mem_req_addr, 26'h10);
    chk("lit_rd_c0_ready", c0_req_ready, 1);
    chk("lit_resp_c0_valid", c0_resp_valid, 1);
    chk("lit_resp_c0_tag", c0_resp_tag, 5'd3);
    chk("lit_resp_c1_valid", c1_resp_valid, 0);
    tick(); idle_inputs();

    // Write burst from c1, c0 waits until the cycle after beat 4.
    tick();
    c1_req_valid = 1; c1_req_rw = 1; c1_req_addr = 26'h20; c1_req_tag = 5'd7; mem_req_ready = 1;
    #3;
    chk("lit_wr_tag", mem_req_tag, 6'h27);
    chk("lit_wr_c1_ready", c1_req_ready, 1);
    for (int k = 0; k < DC; k++) exp_q.push_back(128'hA + 128'(k));
    hs0 = data_hs;
    beats = 0;
    for (int i = 0; i < 8; i++) begin
      tick(); idle_inputs();
      c1_req_data_valid = 1; c1_req_data_bits = 128'hA + 128'(beats);
      mem_req_data_ready = (i % 2 == 0);
      c0_req_valid = 1; c0_req_addr = 26'h44; mem_req_ready = 1;
      #3;
      chk("lit_wr_c0_waits", c0_req_ready, i == 7);
      if (i < 7 && i % 2 == 0) beats++;
    end
    chk("lit_wr_hs_count", data_hs - hs0, DC);
    chk("lit_wr_q_empty", exp_q.size(), 0);

    // Contention: fixed 0,0,0,0 ; round-robin 0,1,0,1.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(); idle_inputs();
      c0_req_valid = 1; c0_req_tag = 5'd1; c1_req_valid = 1; c1_req_tag = 5'd2; mem_req_ready = 1;
`ifdef MIF_ARB_ROUND_ROBIN_EN
      exp_g = (i % 2 == 1);
`else
      exp_g = 1'b0;
`endif
      #3;
      chk("lit_cont_grant", mem_req_tag[CB], exp_g);
    end

    // Backpressure: c0 stalled 3 cycles while c1 joins.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(); idle_inputs();
      c0_req_valid = 1; c0_req_addr = 26'h55; c0_req_tag = 5'd1;
      c1_req_valid = (i >= 1); c1_req_addr = 26'h66; c1_req_tag = 5'd2;
      mem_req_ready = (i == 3);
      #3;
      chk("lit_bp_grant", mem_req_tag[CB], 0);
      chk("lit_bp_addr", mem_req_addr, 26'h55);
      chk("lit_bp_c0_ready", c0_req_ready, i == 3);
      chk("lit_bp_c1_ready", c1_req_ready, 0);
    end

    // Stalled c1 keeps its grant when c0 arrives.
    tick(); idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick(); idle_inputs();
      c1_req_valid = 1; c1_req_addr = 26'h66;
      c0_req_valid = (i >= 1); c0_req_addr = 26'h55;
      mem_req_ready = (i == 2);
      #3;
      chk("lit_hold_grant", mem_req_tag[CB], 1);
      chk("lit_hold_c1_ready", c1_req_ready, i == 2);
      chk("lit_hold_c0_ready", c0_req_ready, 0);
    end

    // Response to c1 during a c0 write burst.
    tick(); idle_inputs();
    c0_req_valid = 1; c0_req_rw = 1; c0_req_addr = 26'h30; c0_req_tag = 5'd4; mem_req_ready = 1;
    for (int k = 0; k < DC; k++) exp_q.push_back(128'h100 + 128'(k));
    for (int i = 0; i < DC; i++) begin
      tick(); idle_inputs();
      c0_req_data_valid = 1; c0_req_data_bits = 128'h100 + 128'(i); mem_req_data_ready = 1;
      mem_resp_valid = (i == 2); mem_resp_tag = 6'h25; mem_resp_data = 128'hBEEF;
      #3;
      if (i == 2) begin
        chk("lit_wresp_c1_valid", c1_resp_valid, 1);
        chk("lit_wresp_c1_tag", c1_resp_tag, 5'd5);
        chk("lit_wresp_c0_valid", c0_resp_valid, 0);
      end
      chk("lit_wresp_c0_data_ready", c0_req_data_ready, 1);
    end
    tick(); idle_inputs();
    chk("lit_wresp_q_empty", exp_q.size(), 0);

    // Reset after beat 2 of a write burst.
    c0_req_valid = 1; c0_req_rw = 1; c0_req_addr = 26'h31; mem_req_ready = 1;
    for (int k = 0; k < 2; k++) exp_q.push_back(128'h200 + 128'(k));
    for (int i = 0; i < 2; i++) begin
      tick(); idle_inputs();
      c0_req_data_valid = 1; c0_req_data_bits = 128'h200 + 128'(i); mem_req_data_ready = 1;
    end
    tick(); reset = 1; c0_req_data_bits = 128'h202;
    tick(); reset = 0;
    c1_req_valid = 1; c1_req_addr = 26'h77; c1_req_tag = 5'd9; mem_req_ready = 1;
    #3;
    chk("lit_rst_mid_c0_data_ready", c0_req_data_ready, 0);
    chk("lit_rst_mid_data_valid", mem_req_data_valid, 0);
    chk("lit_rst_mid_c1_ready", c1_req_ready, 1);
    chk("lit_rst_mid_tag", mem_req_tag, 6'h29);
    chk("lit_rst_mid_q_empty", exp_q.size(), 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      tick();
      reset = ($urandom_range(0, 149) == 0);
      c0_req_valid = $urandom_range(0, 1); c0_req_rw = $urandom_range(0, 2) == 0;
      c0_req_addr = AB'($urandom); c0_req_tag = CB'($urandom);
      c0_req_data_valid = $urandom_range(0, 3) != 0;
      c0_req_data_bits = {$urandom, $urandom, $urandom, $urandom};
      c1_req_valid = $urandom_range(0, 1); c1_req_rw = $urandom_range(0, 2) == 0;
      c1_req_addr = AB'($urandom); c1_req_tag = CB'($urandom);
      c1_req_data_valid = $urandom_range(0, 3) != 0;
      c1_req_data_bits = {$urandom, $urandom, $urandom, $urandom};
      mem_req_ready = $urandom_range(0, 9) < 7;
      mem_req_data_ready = $urandom_range(0, 9) < 7;
      mem_resp_valid = $urandom_range(0, 1);
      mem_resp_tag = (CB+1)'($urandom);
      mem_resp_data = {$urandom, $urandom, $urandom, $urandom};
    end

    tick(); idle_inputs(); reset = 0;
    tick();
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
